// File: rtl/mips_fetch_pkg.sv
// Shared encodings for the fetch stage: control-type codes driven by mips_decode,
// fetch FSM states, and target-address helpers.
package mips_fetch_pkg;

  typedef logic [1:0] ctrl_type_t;

  // Must match the control_type encoding produced by mips_decode.
  localparam ctrl_type_t CT_SEQ    = 2'd0;
  localparam ctrl_type_t CT_BRANCH = 2'd1;
  localparam ctrl_type_t CT_J      = 2'd2;
  localparam ctrl_type_t CT_JR     = 2'd3;

  localparam logic [1:0] ST_START = 2'd0;
  localparam logic [1:0] ST_FETCH = 2'd1;
  localparam logic [1:0] ST_HOLD  = 2'd2;

  function automatic logic [31:0] branch_offset(input logic [15:0] imm);
    return {{14{imm[15]}}, imm, 2'b00};
  endfunction

  function automatic logic [31:0] jump_target(input logic [3:0] region, input logic [25:0] index);
    return {region, index, 2'b00};
  endfunction

endpackage

// File: rtl/mips_next_pc.sv
// Combinational next-PC selection for a retiring instruction; flags any
// redirect to the exception vector.
module mips_next_pc
  import mips_fetch_pkg::*;
#(
  parameter logic [31:0] EXC_VECTOR = 32'h80000180
) (
  // Low 26 bits of the held instruction; the opcode field never affects the target.
  input  logic [25:0] inst,
  input  logic [31:0] pc4,
  input  ctrl_type_t  control_type,
  input  logic        except,
  input  logic [31:0] rs_data,
  output logic [31:0] next_pc,
  output logic        to_exc
);

  always_comb begin
    next_pc = pc4;
    to_exc  = 1'b0;
    if (except) begin
      next_pc = EXC_VECTOR;
      to_exc  = 1'b1;
    end else begin
      case (control_type)
        CT_JR: begin
          // A misaligned register target traps rather than fetching off-word.
          if (rs_data[1:0] != 2'b00) begin
            next_pc = EXC_VECTOR;
            to_exc  = 1'b1;
          end else begin
            next_pc = rs_data;
          end
        end
        CT_J:      next_pc = jump_target(pc4[31:28], inst[25:0]);
        CT_BRANCH: next_pc = pc4 + branch_offset(inst[15:0]);
        CT_SEQ:    next_pc = pc4;
        default:   next_pc = pc4;
      endcase
    end
  end

endmodule

// File: rtl/mips_fetch.sv
// Instruction-fetch stage: owns the PC, fetches over a req/ack handshake, holds the
// instruction for mips_decode and steers the PC when the datapath consumes it.
module mips_fetch
  import mips_fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC   = 32'h00400000,
  parameter logic [31:0] EXC_VECTOR = 32'h80000180
) (
  input  logic        clock,
  input  logic        reset,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic        inst_valid,
  output logic [31:0] inst,
  output logic [31:0] inst_pc,
  output logic [31:0] pc4,
  output logic [5:0]  opcode,
  output logic [5:0]  funct,
  input  ctrl_type_t  control_type,
  input  logic        except,
  input  logic [31:0] rs_data,
  input  logic        consume,
  output logic        exc_taken,
  output logic [31:0] retired
);

  logic [1:0]  state_reg;
  logic [31:0] pc_reg;
  logic        imem_req_reg;
  logic        inst_valid_reg;
  logic [31:0] inst_reg;
  logic [31:0] inst_pc_reg;
  logic        exc_taken_reg;
  logic [31:0] retired_reg;

  logic [31:0] pc4_next;
  logic [31:0] next_pc;
  logic        to_exc;

  assign pc4_next = inst_pc_reg + 32'd4;

  mips_next_pc #(
    .EXC_VECTOR (EXC_VECTOR)
  ) u_next_pc (
    .inst         (inst_reg[25:0]),
    .pc4          (pc4_next),
    .control_type (control_type),
    .except       (except),
    .rs_data      (rs_data),
    .next_pc      (next_pc),
    .to_exc       (to_exc)
  );

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_reg      <= ST_START;
      pc_reg         <= RESET_PC;
      imem_req_reg   <= 1'b0;
      inst_valid_reg <= 1'b0;
      inst_reg       <= 32'd0;
      inst_pc_reg    <= RESET_PC;
      exc_taken_reg  <= 1'b0;
      retired_reg    <= 32'd0;
    end else begin
      exc_taken_reg <= 1'b0;
      case (state_reg)
        // One idle cycle after reset so a stale ack can never be captured.
        ST_START: begin
          imem_req_reg <= 1'b1;
          state_reg    <= ST_FETCH;
        end
        ST_FETCH: begin
          if (imem_ack) begin
            inst_reg       <= imem_rdata;
            inst_pc_reg    <= pc_reg;
            inst_valid_reg <= 1'b1;
            imem_req_reg   <= 1'b0;
            state_reg      <= ST_HOLD;
          end
        end
        ST_HOLD: begin
          if (consume) begin
            pc_reg         <= next_pc;
            inst_valid_reg <= 1'b0;
            imem_req_reg   <= 1'b1;
            retired_reg    <= retired_reg + 32'd1;
            exc_taken_reg  <= to_exc;
            state_reg      <= ST_FETCH;
          end
        end
        default: begin
          imem_req_reg   <= 1'b0;
          inst_valid_reg <= 1'b0;
          state_reg      <= ST_START;
        end
      endcase
    end
  end

  assign imem_req   = imem_req_reg;
  assign imem_addr  = pc_reg;
  assign inst_valid = inst_valid_reg;
  assign inst       = inst_reg;
  assign inst_pc    = inst_pc_reg;
  assign pc4        = pc4_next;
  assign opcode     = inst_reg[31:26];
  assign funct      = inst_reg[5:0];
  assign exc_taken  = exc_taken_reg;
  assign retired    = retired_reg;

endmodule

// File: tb/tb_mips_fetch.sv
// Self-checking bench for mips_fetch: directed sequences, a vector table of PC-steering
// cases and randomized traffic checked against a behavioural next-PC model.
module tb_mips_fetch;

  localparam logic [31:0] RESET_PC   = 32'h00400000;
  localparam logic [31:0] EXC_VECTOR = 32'h80000180;

  logic        clock;
  logic        reset;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic        inst_valid;
  logic [31:0] inst;
  logic [31:0] inst_pc;
  logic [31:0] pc4;
  logic [5:0]  opcode;
  logic [5:0]  funct;
  logic [1:0]  control_type;
  logic        except;
  logic [31:0] rs_data;
  logic        consume;
  logic        exc_taken;
  logic [31:0] retired;

  mips_fetch #(
    .RESET_PC   (RESET_PC),
    .EXC_VECTOR (EXC_VECTOR)
  ) dut (
    .clock        (clock),
    .reset        (reset),
    .imem_req     (imem_req),
    .imem_addr    (imem_addr),
    .imem_ack     (imem_ack),
    .imem_rdata   (imem_rdata),
    .inst_valid   (inst_valid),
    .inst         (inst),
    .inst_pc      (inst_pc),
    .pc4          (pc4),
    .opcode       (opcode),
    .funct        (funct),
    .control_type (control_type),
    .except       (except),
    .rs_data      (rs_data),
    .consume      (consume),
    .exc_taken    (exc_taken),
    .retired      (retired)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int          total = 0;
  int          bad   = 0;
  logic [31:0] exp_retired;
  logic [31:0] ref_pc;
  logic [31:0] held_inst;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] inst;
    int          ct;
    bit          exc;
    logic [31:0] rs;
    logic [31:0] exp_pc;
    bit          exp_exc;
  } vec_t;

  vec_t vecs[9];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  // Architectural next-PC rule, written from the ISA description.
  function automatic logic [31:0] ref_next(input logic [31:0] pc, input logic [31:0] iw,
                                           input int ct, input bit exc, input logic [31:0] rs,
                                           output bit trap);
    logic [31:0] seq;
    int          off;
    seq  = pc + 32'd4;
    trap = 1'b0;
    if (exc || (ct == 3 && (rs % 4) != 0)) begin
      trap = 1'b1;
      return EXC_VECTOR;
    end
    case (ct)
      3:       return rs;
      2:       return (seq & 32'hF0000000) | ((iw & 32'h03FFFFFF) << 2);
      1: begin
        off = int'($signed(iw[15:0]));
        return seq + 32'(off * 4);
      end
      default: return seq;
    endcase
  endfunction

  // Serve one fetch of word after a given number of wait cycles; ends in HOLD.
  task automatic fetch_one(input logic [31:0] word, input int waits);
    int n;
    n = 0;
    while (imem_req !== 1'b1 && n < 8) begin
      step();
      n++;
    end
    check("req_seen", {31'd0, imem_req}, 32'd1);
    for (int w = 0; w < waits; w++) begin
      check("wait_addr", imem_addr, ref_pc);
      check("wait_req", {31'd0, imem_req}, 32'd1);
      check("wait_valid", {31'd0, inst_valid}, 32'd0);
      step();
    end
    check("fetch_addr", imem_addr, ref_pc);
    imem_ack   = 1'b1;
    imem_rdata = word;
    step();
    imem_ack   = 1'b0;
    imem_rdata = $urandom;
    held_inst  = word;
    check("hold_valid", {31'd0, inst_valid}, 32'd1);
    check("hold_req", {31'd0, imem_req}, 32'd0);
    check("hold_inst", inst, word);
    check("hold_inst_pc", inst_pc, ref_pc);
    check("hold_pc4", pc4, ref_pc + 32'd4);
    check("hold_opcode", {26'd0, opcode}, {26'd0, word[31:26]});
    check("hold_funct", {26'd0, funct}, {26'd0, word[5:0]});
  endtask

  // Retire the held instruction with the given decode results; ends in FETCH.
  task automatic consume_one(input int ct, input bit exc, input logic [31:0] rs, input int delay,
                             output bit obs_exc);
    logic [31:0] nxt;
    bit          trap;
    for (int d = 0; d < delay; d++) begin
      step();
      check("delay_valid", {31'd0, inst_valid}, 32'd1);
      check("delay_retired", retired, exp_retired);
    end
    nxt          = ref_next(ref_pc, held_inst, ct, exc, rs, trap);
    control_type = 2'(ct);
    except       = exc;
    rs_data      = rs;
    consume      = 1'b1;
    step();
    consume      = 1'b0;
    except       = 1'b0;
    exp_retired  = exp_retired + 32'd1;
    obs_exc      = exc_taken;
    $display("txn pc=%h inst=%h ct=%0d exc=%0b rs=%h -> next=%h trap=%0b", ref_pc, held_inst, ct, exc, rs, nxt, trap);
    check("cons_valid", {31'd0, inst_valid}, 32'd0);
    check("cons_req", {31'd0, imem_req}, 32'd1);
    check("cons_next_pc", imem_addr, nxt);
    check("cons_exc_taken", {31'd0, exc_taken}, {31'd0, trap});
    check("cons_retired", retired, exp_retired);
    ref_pc = nxt;
    step();
    check("exc_pulse_end", {31'd0, exc_taken}, 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bit          te;
    logic [31:0] w;
    int          rct;
    bit          rexc;
    logic [31:0] rrs;

    vecs[0] = '{32'h00400010, 32'h1000FFFE, 1, 1'b0, 32'h0,        32'h0040000C, 1'b0};
    vecs[1] = '{32'h00400010, 32'h10000003, 1, 1'b0, 32'h0,        32'h00400020, 1'b0};
    vecs[2] = '{32'h00400000, 32'h08100008, 2, 1'b0, 32'h0,        32'h00400020, 1'b0};
    vecs[3] = '{32'h00400040, 32'h03E00008, 3, 1'b0, 32'h00400100, 32'h00400100, 1'b0};
    vecs[4] = '{32'h00400040, 32'h03E00008, 3, 1'b0, 32'h00400102, EXC_VECTOR,   1'b1};
    vecs[5] = '{32'h00400000, 32'h08100008, 2, 1'b1, 32'h0,        EXC_VECTOR,   1'b1};
    vecs[6] = '{32'hFFFFFFFC, 32'h00851020, 0, 1'b0, 32'h0,        32'h00000000, 1'b0};
    vecs[7] = '{32'h90000000, 32'h0BFFFFFF, 2, 1'b0, 32'h0,        32'h9FFFFFFC, 1'b0};
    vecs[8] = '{32'h00400020, 32'h03E00008, 3, 1'b0, 32'h00400001, EXC_VECTOR,   1'b1};

    reset        = 1'b0;
    imem_ack     = 1'b0;
    imem_rdata   = 32'd0;
    control_type = 2'd0;
    except       = 1'b0;
    rs_data      = 32'd0;
    consume      = 1'b0;
    exp_retired  = 32'd0;
    ref_pc       = RESET_PC;
    held_inst    = 32'd0;

    // Reset state
    step();
    step();
    check("rst_req", {31'd0, imem_req}, 32'd0);
    check("rst_valid", {31'd0, inst_valid}, 32'd0);
    check("rst_inst", inst, 32'd0);
    check("rst_inst_pc", inst_pc, RESET_PC);
    check("rst_addr", imem_addr, RESET_PC);
    check("rst_exc", {31'd0, exc_taken}, 32'd0);
    check("rst_retired", retired, 32'd0);
    reset = 1'b1;
    check("start_no_req", {31'd0, imem_req}, 32'd0);
    step();
    check("first_req", {31'd0, imem_req}, 32'd1);
    check("first_addr", imem_addr, RESET_PC);

    // Zero-wait memory with consume held: one retire every two cycles
    imem_ack     = 1'b1;
    imem_rdata   = 32'h00851020;
    consume      = 1'b1;
    control_type = 2'd0;
    step();
    check("tp_valid0", {31'd0, inst_valid}, 32'd1);
    check("tp_inst0", inst, 32'h00851020);
    check("tp_req0", {31'd0, imem_req}, 32'd0);
    step();
    check("tp_valid1", {31'd0, inst_valid}, 32'd0);
    check("tp_addr1", imem_addr, 32'h00400004);
    check("tp_retired1", retired, 32'd1);
    step();
    check("tp_valid2", {31'd0, inst_valid}, 32'd1);
    check("tp_inst_pc2", inst_pc, 32'h00400004);
    step();
    check("tp_valid3", {31'd0, inst_valid}, 32'd0);
    check("tp_addr3", imem_addr, 32'h00400008);
    check("tp_retired3", retired, 32'd2);
    $display("txn throughput: two back-to-back retires ending at pc=%h", imem_addr);
    imem_ack    = 1'b0;
    consume     = 1'b0;
    ref_pc      = 32'h00400008;
    exp_retired = 32'd2;

    // Three wait states, then an ack arriving in HOLD is ignored
    fetch_one(32'h8C430004, 3);
    imem_ack   = 1'b1;
    imem_rdata = 32'hDEADBEEF;
    step();
    imem_ack   = 1'b0;
    check("hold_ack_ignored", inst, 32'h8C430004);
    check("hold_ack_valid", {31'd0, inst_valid}, 32'd1);
    consume_one(0, 1'b0, 32'd0, 1, te);

    // Consume outside HOLD is ignored, including on the ack edge
    consume = 1'b1;
    step();
    check("fetch_consume_retired", retired, exp_retired);
    check("fetch_consume_valid", {31'd0, inst_valid}, 32'd0);
    imem_ack   = 1'b1;
    imem_rdata = 32'h00000000;
    step();
    imem_ack   = 1'b0;
    consume    = 1'b0;
    held_inst  = 32'h00000000;
    check("ack_consume_retired", retired, exp_retired);
    check("ack_consume_valid", {31'd0, inst_valid}, 32'd1);
    consume_one(0, 1'b0, 32'd0, 0, te);

    // PC-steering table: jr to the test PC, then retire the vector instruction
    for (int i = 0; i < 9; i++) begin
      fetch_one(32'h03E00008, 0);
      consume_one(3, 1'b0, vecs[i].pc, 0, te);
      fetch_one(vecs[i].inst, i % 3);
      consume_one(vecs[i].ct, vecs[i].exc, vecs[i].rs, i % 2, te);
      check("vec_next_pc", imem_addr, vecs[i].exp_pc);
      check("vec_exc_taken", {31'd0, te}, {31'd0, vecs[i].exp_exc});
    end

    // Randomized traffic against the reference model
    for (int i = 0; i < 40; i++) begin
      w    = $urandom;
      rct  = int'($urandom_range(0, 3));
      rexc = ($urandom_range(0, 7) == 0);
      rrs  = $urandom;
      if ($urandom_range(0, 3) != 0) rrs[1:0] = 2'b00;
      fetch_one(w, int'($urandom_range(0, 3)));
      consume_one(rct, rexc, rrs, int'($urandom_range(0, 2)), te);
    end

    // Reset mid-FETCH with an ack on the same cycle
    imem_ack   = 1'b1;
    imem_rdata = 32'h12345678;
    #2;
    reset = 1'b0;
    #1;
    check("arst_req", {31'd0, imem_req}, 32'd0);
    check("arst_valid", {31'd0, inst_valid}, 32'd0);
    check("arst_inst", inst, 32'd0);
    check("arst_addr", imem_addr, RESET_PC);
    check("arst_retired", retired, 32'd0);
    check("arst_exc", {31'd0, exc_taken}, 32'd0);
    step();
    reset = 1'b1;
    check("arst_start_req", {31'd0, imem_req}, 32'd0);
    step();
    check("arst_late_ack_valid", {31'd0, inst_valid}, 32'd0);
    check("arst_first_req", {31'd0, imem_req}, 32'd1);
    check("arst_first_addr", imem_addr, RESET_PC);
    imem_ack    = 1'b0;
    ref_pc      = RESET_PC;
    exp_retired = 32'd0;
    $display("txn reset mid-fetch: restart at pc=%h", imem_addr);
    fetch_one(32'h00851020, 1);
    consume_one(0, 1'b0, 32'd0, 0, te);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mips_fetch.md
Name: mips_fetch

Overview:
- Instruction-fetch stage sitting directly upstream of mips_decode.
- Holds the PC and fetches 32-bit words over a req/ack handshake from instruction memory.
- Presents opcode/funct to the decoder and holds the instruction until the datapath consumes it.
- On consume, applies the decoder's control_type and except outputs to select the next PC.

Parameters:
- RESET_PC, 32'h00400000, PC loaded on reset.
- EXC_VECTOR, 32'h80000180, PC loaded on exception or misaligned jr target.

Ports:
- clock  input  1  single clock; all state updates on rising edge.
- reset  input  1  one clock; reset is asynchronous and active-low (0 = reset).
- imem_req  output  1  fetch request, registered.
- imem_addr  output  32  byte address of the fetch, equals pc, word aligned.
- imem_ack  input  1  memory returns imem_rdata this cycle.
- imem_rdata  input  32  fetched instruction word.
- inst_valid  output  1  inst/inst_pc are valid and held.
- inst  output  32  held instruction.
- inst_pc  output  32  address of the held instruction.
- pc4  output  32  inst_pc + 4, modulo 2^32.
- opcode  output  6  inst[31:26], to mips_decode.
- funct  output  6  inst[5:0], to mips_decode.
- control_type  input  2  from mips_decode: 0 seq, 1 branch taken, 2 j, 3 jr.
- except  input  1  from mips_decode.
- rs_data  input  32  register rs value, used as the jr target.
- consume  input  1  datapath retires the held instruction.
- exc_taken  output  1  one-cycle pulse when the PC is redirected to EXC_VECTOR.
- retired  output  32  count of consumed instructions; wraps at 2^32.

Behaviour:
- Reset values (async, while reset=0):
  - pc = RESET_PC, state = START.
  - imem_req = 0, inst_valid = 0, inst = 0, inst_pc = RESET_PC.
  - exc_taken = 0, retired = 0.
- States: START, FETCH, HOLD.
- START:
  - Next edge: imem_req <= 1, go to FETCH.
  - Ensures no request is issued in the first cycle after reset release.
- FETCH:
  - imem_req = 1; imem_addr = pc, stable until ack.
  - On an edge with imem_ack = 1: inst <= imem_rdata, inst_pc <= pc, inst_valid <= 1, imem_req <= 0, go to HOLD.
  - imem_ack = 0: stay in FETCH; any number of wait cycles is allowed.
- HOLD:
  - inst_valid = 1; inst, opcode and funct are stable.
  - consume = 0: stay in HOLD.
  - consume = 1 on an edge: pc <= next_pc, inst_valid <= 0, imem_req <= 1, retired += 1, go to FETCH.
- next_pc, in priority order:
  - except = 1 → EXC_VECTOR.
  - control_type = 3 and rs_data[1:0] != 0 → EXC_VECTOR.
  - control_type = 3 → rs_data.
  - control_type = 2 → {pc4[31:28], inst[25:0], 2'b00}.
  - control_type = 1 → pc4 + sign-extended (inst[15:0] << 2).
  - Otherwise → pc4.
  - All adds are modulo 2^32: pc 32'hFFFFFFFC with seq gives 0.
- exc_taken is high for exactly the cycle after a consume edge whose next_pc came from either EXC_VECTOR rule; otherwise 0.
- imem_ack outside FETCH (imem_req = 0) is ignored; no state change.
- consume outside HOLD is ignored; retired does not change.
- Throughput: with a zero-wait memory (ack in the first FETCH cycle) and consume asserted immediately, one instruction retires every 2 cycles.
- Reset asserted mid-FETCH or mid-HOLD:
  - Outputs clear immediately.
  - A late ack after reset release is ignored because the block is in START.

Decomposition:
- Shared defines header, alongside the existing OP_ and OP0_ opcode macros:
  - Control-type encodings CT_SEQ = 0, CT_BRANCH = 1, CT_J = 2, CT_JR = 3. These must match what mips_decode drives.
  - Fetch state encodings.
- One combinational sub-module, mips_next_pc.
  - Inputs: inst, pc4, control_type, except, rs_data.
  - Outputs: next_pc, to_exc.
  - Unit-testable alone.
- The FSM, handshake registers and retired counter stay in mips_fetch.

Test Plan:
1. Reset release, zero-wait memory returns 32'h00851020 (add) at 32'h00400000, consume held 1, control_type 0 → second request at 32'h00400004; inst_valid high one cycle per instruction; retired = 1.
2. Memory waits 3 cycles before ack → imem_req high and imem_addr stable all 4 cycles; inst_valid rises the cycle after ack.
3. Hold the beq at pc 32'h00400010 (inst[15:0] = 16'hFFFE) and consume with control_type 1 → next fetch 32'h0040000C. Repeat with inst[15:0] = 16'h0003 → 32'h00400020.
4. Jump and jr cases:
   - j with inst[25:0] = 26'h0100008 at pc 32'h00400000 → 32'h00400020.
   - jr with rs_data = 32'h00400100 → 32'h00400100.
   - jr with rs_data = 32'h00400102 → EXC_VECTOR and an exc_taken pulse.
5. except = 1 at consume while control_type = 2 → pc = 32'h80000180, exc_taken high exactly one cycle, retired still increments.
6. Reset driven low while in FETCH with ack arriving the same cycle → outputs clear asynchronously; after release the first request is at RESET_PC, issued after one START cycle.
